// File: rtl/control_unit_if.sv
// Bus between instruction memory / datapath and the control unit.
// The instruction field and live ALU flags flow into the control unit;
// the decoded datapath controls flow back out. Everything on this bus is
// combinational within a cycle, so there is no valid/ready pairing.
`timescale 1ns/1ps

interface control_unit_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemWrite;
    logic        MemtoReg;
    logic        PCSrc;

    // Datapath side: supplies the instruction and ALU flags, consumes controls.
    modport master (
        output Instr, ALUFlags,
        input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
               MemWrite, MemtoReg, PCSrc
    );

    // Control unit side.
    modport slave (
        input  Instr, ALUFlags,
        output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
               MemWrite, MemtoReg, PCSrc
    );
endinterface

// File: rtl/control_unit.sv
// Control unit for the single-cycle ARM-subset core.
// Decodes Instr[31:12] into datapath controls, keeps the NZCV flags and
// gates every state-changing control with the instruction's condition code.
// All outputs are combinational; only the flags are registered.
`timescale 1ns/1ps

module control_unit (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.slave cu
);

    // Instruction fields (bit positions are relative to Instr[31:12]).
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] unused_rn;

    assign cond      = cu.Instr[19:16];
    assign op        = cu.Instr[15:14];
    assign funct     = cu.Instr[13:8];
    assign unused_rn = cu.Instr[7:4];
    assign rd        = cu.Instr[3:0];

    // Main decoder outputs (ungated).
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;

    // ALU decoder outputs.
    logic [1:0] alu_control;
    logic [1:0] flag_w;

    // PC logic and condition logic.
    logic       pcs;
    logic       cond_ex;
    logic [1:0] flag_write;

    // Stored flags: N,Z form one write group, C,V the other.
    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       n_f, z_f, c_f, v_f;

    assign n_f = nz_q[1];
    assign z_f = nz_q[0];
    assign c_f = cv_q[1];
    assign v_f = cv_q[0];

    // Main decoder: instruction class from Op and Funct.
    always_comb begin
        reg_src    = 2'b00;
        imm_src    = 2'b00;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (op)
            2'b00: begin
                // Data processing; Funct[5] is the immediate (I) bit.
                alu_src = funct[5];
                reg_w   = 1'b1;
                alu_op  = 1'b1;
            end
            2'b01: begin
                imm_src = 2'b01;
                alu_src = 1'b1;
                if (funct[0]) begin
                    // LDR
                    mem_to_reg = 1'b1;
                    reg_w      = 1'b1;
                end else begin
                    // STR: the store data register comes from the Rd field.
                    reg_src = 2'b10;
                    mem_w   = 1'b1;
                end
            end
            2'b10: begin
                // B: base is the PC, offset is the 24-bit branch immediate.
                reg_src = 2'b01;
                imm_src = 2'b10;
                alu_src = 1'b1;
                branch  = 1'b1;
            end
            default: begin
                // Op=11 is undefined: leave every control deasserted.
            end
        endcase
    end

    // ALU decoder: operation and flag-write enables for data processing.
    always_comb begin
        alu_control = 2'b00;
        flag_w      = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: begin // ADD
                    alu_control = 2'b00;
                    flag_w      = {funct[0], funct[0]};
                end
                4'b0010: begin // SUB
                    alu_control = 2'b01;
                    flag_w      = {funct[0], funct[0]};
                end
                4'b0000: begin // AND: logic ops leave C and V untouched
                    alu_control = 2'b10;
                    flag_w      = {funct[0], 1'b0};
                end
                4'b1100: begin // ORR
                    alu_control = 2'b11;
                    flag_w      = {funct[0], 1'b0};
                end
                default: begin
                    // Unsupported command: behave as ADD without flag update.
                    alu_control = 2'b00;
                    flag_w      = 2'b00;
                end
            endcase
        end
    end

    // PC logic: branches and any register write to R15 redirect the PC.
    always_comb begin
        pcs = branch | ((rd == 4'b1111) & reg_w);
    end

    // Condition check against the stored flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;                          // EQ
            4'b0001: cond_ex = ~z_f;                         // NE
            4'b0010: cond_ex = c_f;                          // CS
            4'b0011: cond_ex = ~c_f;                         // CC
            4'b0100: cond_ex = n_f;                          // MI
            4'b0101: cond_ex = ~n_f;                         // PL
            4'b0110: cond_ex = v_f;                          // VS
            4'b0111: cond_ex = ~v_f;                         // VC
            4'b1000: cond_ex = c_f & ~z_f;                   // HI
            4'b1001: cond_ex = ~(c_f & ~z_f);                // LS
            4'b1010: cond_ex = ~(n_f ^ v_f);                 // GE
            4'b1011: cond_ex = n_f ^ v_f;                    // LT
            4'b1100: cond_ex = ~z_f & ~(n_f ^ v_f);          // GT
            4'b1101: cond_ex = ~(~z_f & ~(n_f ^ v_f));       // LE
            4'b1110: cond_ex = 1'b1;                         // AL
            default: cond_ex = 1'b0;                         // 1111: never
        endcase
    end

    // A condition-failed instruction must not touch the flags.
    assign flag_write = flag_w & {2{cond_ex}};

    // N,Z flag group register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nz_q <= 2'b00;
        end else if (flag_write[1]) begin
            nz_q <= cu.ALUFlags[3:2];
        end
    end

    // C,V flag group register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cv_q <= 2'b00;
        end else if (flag_write[0]) begin
            cv_q <= cu.ALUFlags[1:0];
        end
    end

    // Drive the bus: state-changing controls are condition-gated, the rest pass through.
    assign cu.RegSrc     = reg_src;
    assign cu.ImmSrc     = imm_src;
    assign cu.ALUSrc     = alu_src;
    assign cu.ALUControl = alu_control;
    assign cu.MemtoReg   = mem_to_reg;
    assign cu.RegWrite   = reg_w & cond_ex;
    assign cu.MemWrite   = mem_w & cond_ex;
    assign cu.PCSrc      = pcs & cond_ex;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction checks followed by random
// instructions, all compared against an architectural reference model.
`timescale 1ns/1ps

module tb_control_unit;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    control_unit_if cu_bus ();

    control_unit dut (
        .clk   (clk),
        .reset (reset),
        .cu    (cu_bus)
    );

    // ---------------- reference model state ----------------
    // Architectural NZCV as the program sees it.
    logic m_n, m_z, m_c, m_v;

    // Scoreboard
    logic [10:0] exp_q[$];
    int n_cmp;
    int n_bad;

    // Does the condition field pass with the model's flags?
    function automatic logic ref_cond(input logic [3:0] c);
        logic ge, hi;
        ge = (m_n == m_v);
        hi = m_c && !m_z;
        case (c)
            4'd0:  return m_z;
            4'd1:  return !m_z;
            4'd2:  return m_c;
            4'd3:  return !m_c;
            4'd4:  return m_n;
            4'd5:  return !m_n;
            4'd6:  return m_v;
            4'd7:  return !m_v;
            4'd8:  return hi;
            4'd9:  return !hi;
            4'd10: return ge;
            4'd11: return !ge;
            4'd12: return !m_z && ge;
            4'd13: return !(!m_z && ge);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Architectural decode of one instruction: returns the expected output
    // vector {RegSrc,RegWrite,ImmSrc,ALUSrc,ALUControl,MemWrite,MemtoReg,PCSrc}
    // and which flag groups ({NZ,CV}) this instruction would write.
    task automatic ref_decode(input logic [19:0] i, output logic [10:0] outs,
                              output logic [1:0] fw);
        logic [3:0] c, cmd, rd;
        logic [1:0] op;
        logic       ibit, sbit, pass;
        logic [1:0] rsrc, isrc, actl;
        logic       asrc, m2r, wr_reg, wr_mem, is_branch, writes_pc;
        logic       arith, logic_op;
        c    = i[19:16];
        op   = i[15:14];
        ibit = i[13];
        cmd  = i[12:9];
        sbit = i[8];
        rd   = i[3:0];
        pass = ref_cond(c);
        rsrc = 2'b00; isrc = 2'b00; actl = 2'b00;
        asrc = 0; m2r = 0; wr_reg = 0; wr_mem = 0; is_branch = 0;
        fw   = 2'b00;
        if (op == 2'b00) begin
            asrc     = ibit;
            wr_reg   = 1;
            arith    = (cmd == 4'b0100) || (cmd == 4'b0010);
            logic_op = (cmd == 4'b0000) || (cmd == 4'b1100);
            if (cmd == 4'b0010) actl = 2'b01;
            else if (cmd == 4'b0000) actl = 2'b10;
            else if (cmd == 4'b1100) actl = 2'b11;
            if (arith || logic_op) fw = {sbit, sbit && arith};
        end else if (op == 2'b01) begin
            isrc = 2'b01;
            asrc = 1;
            if (sbit) begin m2r = 1; wr_reg = 1; end   // Funct[0]=L bit
            else begin rsrc = 2'b10; wr_mem = 1; end
        end else if (op == 2'b10) begin
            rsrc = 2'b01; isrc = 2'b10; asrc = 1; is_branch = 1;
        end
        writes_pc = is_branch || (wr_reg && rd == 4'hF);
        outs = {rsrc, wr_reg && pass, isrc, asrc, actl, wr_mem && pass, m2r,
                writes_pc && pass};
        fw = pass ? fw : 2'b00;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [19:0] instr, input logic [3:0] aflags);
        cu_bus.Instr    = instr;
        cu_bus.ALUFlags = aflags;
        #1;
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (!v) begin
            m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        end
        #1;
    endtask

    // One rising edge; the model commits the flags the current instruction writes.
    task automatic tick();
        logic [10:0] o;
        logic [1:0]  fw;
        ref_decode(cu_bus.Instr, o, fw);
        @(posedge clk);
        if (reset) begin
            if (fw[1]) begin m_n = cu_bus.ALUFlags[3]; m_z = cu_bus.ALUFlags[2]; end
            if (fw[0]) begin m_c = cu_bus.ALUFlags[1]; m_v = cu_bus.ALUFlags[0]; end
        end
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag);
        logic [10:0] o, e, obs;
        logic [1:0]  fw;
        ref_decode(cu_bus.Instr, o, fw);
        exp_q.push_back(o);
        e   = exp_q.pop_front();
        obs = {cu_bus.RegSrc, cu_bus.RegWrite, cu_bus.ImmSrc, cu_bus.ALUSrc,
               cu_bus.ALUControl, cu_bus.MemWrite, cu_bus.MemtoReg, cu_bus.PCSrc};
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s instr=%05h nzcv=%b%b%b%b observed=%03h expected=%03h",
                   tag, cu_bus.Instr, m_n, m_z, m_c, m_v, obs, e);
        end
    endtask

    // Random instruction biased toward meaningful encodings.
    function automatic logic [19:0] rand_instr();
        logic [3:0] c, cmd, rd, rn;
        logic [1:0] op;
        logic [5:0] f;
        int sel;
        c   = 4'($urandom_range(0, 15));
        rn  = 4'($urandom_range(0, 15));
        rd  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        op  = 2'($urandom_range(0, 3));
        sel = $urandom_range(0, 4);
        case (sel)
            0: cmd = 4'b0100;
            1: cmd = 4'b0010;
            2: cmd = 4'b0000;
            3: cmd = 4'b1100;
            default: cmd = 4'($urandom_range(0, 15));
        endcase
        f = {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))};
        return {c, op, f, rn, rd};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        cu_bus.Instr    = 20'h0;
        cu_bus.ALUFlags = 4'h0;
        set_reset(1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state: all flags clear.
        drive(20'h0A000, 4'hF); check("rst_beq");
        drive(20'h1A000, 4'hF); check("rst_bne");
        tick();
        drive(20'h0A000, 4'h0); check("rst_hold_beq");
        set_reset(1'b1);

        // Decoder, one per instruction class.
        drive(20'hE004F, 4'h0); check("dp_reg_rd15");
        drive(20'hE2800, 4'h0); check("add_imm");
        drive(20'hE5901, 4'h0); check("ldr");
        drive(20'hE5801, 4'h0); check("str");
        drive(20'hEA000, 4'h0); check("b_al");
        drive(20'hE280F, 4'h0); check("add_imm_rd15");
        drive(20'hE2410, 4'h0); check("sub_imm");
        drive(20'hE1800, 4'h0); check("orr_reg");
        drive(20'hE0E00, 4'h0); check("unsup_cmd");
        drive(20'hEC000, 4'h0); check("undef_op");
        drive(20'hF2800, 4'h0); check("cond_never");

        // SUBS sets Z, BEQ taken next cycle.
        drive(20'hE2500, 4'b0100); check("subs_z");
        tick();
        drive(20'h0A000, 4'h0); check("beq_taken");
        drive(20'h1A000, 4'h0); check("bne_not");

        // SUBS clears Z, BEQ not taken.
        drive(20'hE2500, 4'b0000); tick();
        drive(20'h0A000, 4'h0); check("beq_not");

        // Condition-failed SUBSEQ must not write the flags.
        drive(20'h02500, 4'b0100); check("subseq_fail");
        tick();
        drive(20'h0A000, 4'h0); check("beq_after_fail");

        // ANDS writes N,Z but not C,V.
        drive(20'hE2500, 4'b0011); tick();
        drive(20'hE0100, 4'b1100); tick();
        drive(20'h2A000, 4'h0); check("bcs_after_ands");
        drive(20'h4A000, 4'h0); check("bmi_after_ands");

        // Asynchronous reset clears flags with no clock edge.
        drive(20'hE2500, 4'b0100); tick();
        drive(20'h0A000, 4'h0); check("beq_pre_rst");
        #2;
        set_reset(1'b0);
        drive(20'h0A000, 4'h0); check("beq_async_rst");
        drive(20'h1A000, 4'h0); check("bne_async_rst");
        drive(20'hE2500, 4'b0100); tick();
        drive(20'h0A000, 4'h0); check("beq_rst_held");
        set_reset(1'b1);

        // Random instruction stream with occasional resets.
        for (int k = 0; k < 600; k++) begin
            drive(rand_instr(), 4'($urandom_range(0, 15)));
            check("rand");
            if ($urandom_range(0, 60) == 0) begin
                set_reset(1'b0);
                check("rand_rst");
                set_reset(1'b1);
            end
            tick();
        end

        if (exp_q.size() != 0) begin
            n_bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
